pwm_peripheral: RTL and testbench
=================================

Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register file. Takes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives 16 output pins.
- Each pin is one of: forced low, forced high, or a PWM waveform shared by all PWM-enabled pins.
- A prescaled 8-bit timebase sets the PWM period. The duty value is double-buffered so that a duty change never glitches a period mid-flight.

Parameters:
- PRESCALE, 13, clk cycles per PWM tick; must be >= 1. At 10 MHz: 10e6/(13*255) ≈ 3.0 kHz.
- PERIOD_TICKS, 255, ticks per PWM period; the period counter runs 0..254.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-high (asserted = 1), despite the name
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM mode select, pins 15..8
- pwm_duty_cycle  input  8  duty value; 0 = always low, 255 = always high
- pwm_out  output  16  pin drive; bit i = pin i
- period_start  output  1  one-clk pulse when the period counter wraps to 0

Behaviour:
- Reset (rst_n=1, async):
  - pre_cnt=0, per_cnt=0, duty_shadow=0.
  - pwm_out=16'h0000, period_start=0.
  - Effect is immediate, with no clk required; mid-period reset discards the period in progress.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick is high in the cycle where pre_cnt==PRESCALE-1.
  - PRESCALE=1 means tick is high every cycle.
- Period counter:
  - Advances only on tick.
  - At per_cnt==PERIOD_TICKS-1 (254), the next value is 0; otherwise the next value is per_cnt+1.
- Duty shadow:
  - Loads pwm_duty_cycle on the clk edge where tick && per_cnt==254, i.e. as per_cnt becomes 0.
  - period_start is registered high on that same edge, for 1 cycle.
  - Any duty change between wraps takes effect only at the next period start.
- Waveform:
  - pwm_raw = (per_cnt < duty_shadow), as an unsigned 8-bit compare.
  - duty 0: pwm_raw always 0.
  - duty 255: pwm_raw always 1, because per_cnt never reaches 255.
  - Duty N gives N high ticks out of 255.
- Per-pin selection, computed combinationally then registered into pwm_out[i]:
  - en_out[i]=0: drives 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0: drives 1.
  - en_out[i]=1, en_pwm[i]=1: drives pwm_raw.
- Latency:
  - pwm_out reflects enable-register changes 1 clk after they are sampled, with no period alignment.
  - pwm_out edges lag per_cnt transitions by 1 clk.
- Simultaneous events: a duty change and a wrap on the same edge load the new duty, because the register value present at that edge is taken.
- First period after reset: duty_shadow=0, so PWM pins stay low until the first wrap.
  - With PRESCALE=13, the first wrap occurs 13*255 clks after reset release.
- Inputs are treated as stable clk-domain registers; no synchronizers are used here.
- All state is flops on clk, asynchronously reset by rst_n; no latches.

Decomposition:
- Shared package pwm_pkg holds:
  - PWM_CNT_W=8, DUTY_W=8, NUM_PINS=16, default PRESCALE and PERIOD_TICKS.
  - Pin-mode enum: PIN_OFF, PIN_ON, PIN_PWM.
- One natural sub-module, pwm_timebase:
  - Contains the prescaler and period counter.
  - Outputs per_cnt[7:0], tick and wrap.
  - pwm_peripheral instantiates it and adds the duty shadow, the compare, the 16-way pin mux and the output register.

Test Plan:
- Reset held 1 while clk toggles, enables=FF/FF/00/00 -> pwm_out=0000 and period_start=0 throughout; after release, pwm_out=FFFF one clk after the first sampled edge.
- PRESCALE=2, en_out=00FF, en_pwm=00FF, duty=128 -> after the first wrap, pins 7..0 are high exactly 256 clks and low 254 clks per 510-clk period; pins 15..8 are 0.
- Duty 0 and duty 255 with all pins in PWM mode -> pwm_out=0000 constant, and FFFF constant after the first wrap; never a 1-clk glitch across the wrap.
- Duty changed 64->192 at per_cnt=100 -> current period keeps 64 high ticks; the next period (after the period_start pulse) has 192 high ticks.
- Mixed modes: en_out=A5A5, en_pwm=0F0F, duty=50 -> bits with en_out=0 are 0; en_out=1 with en_pwm=0 are 1; remaining bits follow the waveform; a flip of en_out bit 0 appears on pwm_out 1 clk later mid-period.
- Async reset asserted mid-period for 1 ns, between clk edges -> pwm_out goes to 0000 immediately; per_cnt restarts at 0; duty_shadow=0 until the next wrap.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths, default timing parameters and pin-mode decoding for the PWM peripheral.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int PWM_CNT_W        = 8;
  localparam int DUTY_W           = 8;
  localparam int NUM_PINS         = 16;
  localparam int PRESCALE_DEF     = 13;
  localparam int PERIOD_TICKS_DEF = 255;

  typedef enum logic [1:0] {
    PIN_OFF,
    PIN_ON,
    PIN_PWM
  } pin_mode_t;

  // Output enable dominates: a disabled pin is low whatever its PWM select says.
  function automatic pin_mode_t pin_mode(input logic en_out, input logic en_pwm);
    pin_mode_t m;
    if (!en_out)     m = PIN_OFF;
    else if (en_pwm) m = PIN_PWM;
    else             m = PIN_ON;
    return m;
  endfunction

  function automatic logic pin_drive(input pin_mode_t m, input logic pwm_raw);
    logic d;
    case (m)
      PIN_ON:  d = 1'b1;
      PIN_PWM: d = pwm_raw;
      default: d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus period counter; tick marks each PWM tick, wrap marks the last tick of a period.
`timescale 1ns/1ps
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE     = PRESCALE_DEF,
  parameter int PERIOD_TICKS = PERIOD_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] per_cnt,
  output logic                 tick,
  output logic                 wrap
);

  // A 1-bit prescaler covers PRESCALE=1, where it sits at 0 and ticks every cycle.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_CNT_W-1:0] PER_MAX = PWM_CNT_W'(PERIOD_TICKS - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (per_cnt == PER_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      per_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) per_cnt <= (per_cnt == PER_MAX) ? '0 : per_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Sixteen-pin output stage: each pin is forced low, forced high, or follows one shared PWM
// waveform whose duty is double-buffered so it only changes at a period boundary.
`timescale 1ns/1ps
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE     = PRESCALE_DEF,
  parameter int PERIOD_TICKS = PERIOD_TICKS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  logic [PWM_CNT_W-1:0] per_cnt;
  logic                 tick;
  logic                 wrap;
  logic [DUTY_W-1:0]    duty_shadow;
  logic                 pwm_raw;
  logic [NUM_PINS-1:0]  en_out;
  logic [NUM_PINS-1:0]  en_pwm;
  logic [NUM_PINS-1:0]  pin_next;

  // rst_n is active-high despite its name.
  pwm_timebase #(
    .PRESCALE     (PRESCALE),
    .PERIOD_TICKS (PERIOD_TICKS)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst_n),
    .per_cnt (per_cnt),
    .tick    (tick),
    .wrap    (wrap)
  );

  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  // per_cnt never reaches 255, so duty 255 holds the waveform high for the whole period.
  assign pwm_raw = (per_cnt < duty_shadow);

  always_comb begin
    pin_next = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      pin_next[i] = pin_drive(pin_mode(en_out[i], en_pwm[i]), pwm_raw);
    end
  end

  // The duty sampled on the wrap edge governs the whole period that starts there.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      duty_shadow  <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
    end else begin
      if (tick && wrap) duty_shadow <= pwm_duty_cycle;
      period_start <= tick && wrap;
      pwm_out      <= pin_next;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with PRESCALE=2 (510-clk period, first wrap 510 clks after release).
`timescale 1ns/1ps
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  en_reg_out_7_0 = 8'hFF;
  logic [7:0]  en_reg_out_15_8 = 8'hFF;
  logic [7:0]  en_reg_pwm_7_0 = 8'h00;
  logic [7:0]  en_reg_pwm_15_8 = 8'h00;
  logic [7:0]  pwm_duty_cycle = 8'd0;
  logic [15:0] pwm_out;
  logic        period_start;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .PRESCALE     (2),
    .PERIOD_TICKS (255)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .pwm_out         (pwm_out),
    .period_start    (period_start)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // cyc counts posedges since the last reset release; samples land 1 ns after each edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("reset_pwm_out", 32'(pwm_out), 32'h0);
      chk("reset_period_start", 32'(period_start), 32'h0);
    end
    rst_n = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_ps(input string tag, input int exp_cyc);
    int seen;
    seen = -1;
    for (int n = 0; n < 600 && seen < 0; n++) begin
      step();
      if (period_start) seen = cyc;
    end
    chk(tag, 32'(seen), 32'(exp_cyc));
  endtask

  initial begin
    int hi;
    int bad;
    int ps_at;

    // Reset held while clocking, then static all-on pins one clk after release.
    do_reset();
    step();
    chk("t1_release_out", 32'(pwm_out), 32'hFFFF);

    // Duty 128 on pins 7..0: 256 high / 254 low clks per 510-clk period.
    en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'h00;
    en_reg_pwm_7_0 = 8'hFF; en_reg_pwm_15_8 = 8'h00;
    pwm_duty_cycle = 8'd128;
    do_reset();
    wait_ps("t2_first_wrap", 510);
    chk("t2_wrap_out", 32'(pwm_out), 32'h0);
    hi = 0; bad = 0; ps_at = -1;
    for (int n = 0; n < 510; n++) begin
      step();
      if (pwm_out == 16'h00FF) hi++;
      else if (pwm_out != 16'h0000) bad++;
      if (period_start) begin
        if (ps_at < 0) ps_at = cyc;
        else bad++;
      end
    end
    chk("t2_high_clks", 32'(hi), 32'd256);
    chk("t2_bad_samples", 32'(bad), 32'd0);
    chk("t2_second_wrap", 32'(ps_at), 32'd1020);

    // Duty 0, all pins PWM: constant low.
    en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0 = 8'hFF; en_reg_pwm_15_8 = 8'hFF;
    pwm_duty_cycle = 8'd0;
    do_reset();
    bad = 0;
    for (int n = 0; n < 1100; n++) begin
      step();
      if (pwm_out != 16'h0000) bad++;
    end
    chk("t3_duty0_nonzero", 32'(bad), 32'd0);

    // Duty 255: low until the first wrap lands, then solid high across later wraps.
    pwm_duty_cycle = 8'd255;
    do_reset();
    bad = 0; hi = 0;
    for (int n = 0; n < 1600; n++) begin
      step();
      if (cyc <= 510) begin
        if (pwm_out != 16'h0000) bad++;
      end else if (pwm_out == 16'hFFFF) hi++;
    end
    chk("t3_duty255_pre", 32'(bad), 32'd0);
    chk("t3_duty255_high", 32'(hi), 32'd1090);

    // Duty 64 -> 192 changed at per_cnt=100: takes effect only in the next period.
    pwm_duty_cycle = 8'd64;
    do_reset();
    wait_ps("t4_first_wrap", 510);
    hi = 0; ps_at = -1;
    for (int n = 0; n < 510; n++) begin
      step();
      if (cyc == 710) pwm_duty_cycle = 8'd192;
      if (pwm_out == 16'hFFFF) hi++;
      if (period_start && ps_at < 0) ps_at = cyc;
    end
    chk("t4_old_duty_high", 32'(hi), 32'd128);
    chk("t4_wrap", 32'(ps_at), 32'd1020);
    hi = 0;
    for (int n = 0; n < 510; n++) begin
      step();
      if (pwm_out == 16'hFFFF) hi++;
    end
    chk("t4_new_duty_high", 32'(hi), 32'd384);

    // Mixed modes: static-on bits A0A0, PWM bits 0505, duty 50.
    en_reg_out_7_0 = 8'hA5; en_reg_out_15_8 = 8'hA5;
    en_reg_pwm_7_0 = 8'h0F; en_reg_pwm_15_8 = 8'h0F;
    pwm_duty_cycle = 8'd50;
    do_reset();
    step();
    chk("t5_pre_wrap", 32'(pwm_out), 32'hA0A0);
    wait_ps("t5_first_wrap", 510);
    while (cyc < 600) step();
    chk("t5_pwm_high", 32'(pwm_out), 32'hA5A5);
    en_reg_out_7_0 = 8'hA4;
    step();
    chk("t5_en_flip", 32'(pwm_out), 32'hA5A4);
    en_reg_out_7_0 = 8'hA5;
    step();
    chk("t5_en_restore", 32'(pwm_out), 32'hA5A5);
    while (cyc < 620) step();
    chk("t5_pwm_low", 32'(pwm_out), 32'hA0A0);

    // Short async reset between edges clears outputs at once and restarts the period.
    #2;
    rst_n = 1'b1;
    #0.5;
    chk("t6_async_out", 32'(pwm_out), 32'h0);
    chk("t6_async_ps", 32'(period_start), 32'h0);
    #0.5;
    rst_n = 1'b0;
    cyc = 0;
    step();
    chk("t6_after_release", 32'(pwm_out), 32'hA0A0);
    wait_ps("t6_first_wrap", 510);
    step();
    chk("t6_after_wrap", 32'(pwm_out), 32'hA5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
